// File: rtl/id_if.sv
// Fetch/decode/writeback bundle seen by the decode stage.
// The slave side is the decode stage; the master side drives fetch, EX and writeback inputs.
interface id_if #(parameter int SIZE = 32);
    logic [SIZE-1:0] Instruction;
    logic [SIZE-1:0] PC4;
    logic            redirect;
    logic            wbWe;
    logic [4:0]      wbAddr;
    logic [SIZE-1:0] wbData;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [10:0]     control;
    logic            stall;
    logic [10:0]     controlEX;
    logic [4:0]      writeRegEX;
    logic [SIZE-1:0] readData1EX;
    logic [SIZE-1:0] readData2EX;
    logic [SIZE-1:0] immEX;
    logic [SIZE-1:0] PC4EX;

    modport slave (
        input  Instruction, PC4, redirect, wbWe, wbAddr, wbData,
        output rs, rt, control, stall, controlEX, writeRegEX,
               readData1EX, readData2EX, immEX, PC4EX
    );

    modport master (
        output Instruction, PC4, redirect, wbWe, wbAddr, wbData,
        input  rs, rt, control, stall, controlEX, writeRegEX,
               readData1EX, readData2EX, immEX, PC4EX
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file with write bypass, control decode, load-use
// hazard detection and the ID/EX pipeline register with bubble injection.
module id_stage #(
    parameter int SIZE = 32,
    parameter int REGS = 32
) (
    input  logic clk,
    input  logic rst_n,
    id_if.slave  bus
);
    logic [SIZE-1:0] regs_q [REGS];
    logic [SIZE-1:0] regs_d [REGS];

    logic [5:0]      opcode;
    logic [4:0]      rd;
    logic [10:0]     ctrl;
    logic [SIZE-1:0] imm;
    logic [SIZE-1:0] rd1, rd2;
    logic [4:0]      dest;

    logic [10:0]     ctrl_ex_q, ctrl_ex_d;
    logic [4:0]      wr_ex_q, wr_ex_d;
    logic [SIZE-1:0] rd1_ex_q, rd1_ex_d;
    logic [SIZE-1:0] rd2_ex_q, rd2_ex_d;
    logic [SIZE-1:0] imm_ex_q, imm_ex_d;
    logic [SIZE-1:0] pc4_ex_q, pc4_ex_d;

    assign opcode = bus.Instruction[31:26];
    assign bus.rs = bus.Instruction[25:21];
    assign bus.rt = bus.Instruction[20:16];
    assign rd     = bus.Instruction[15:11];

    always_comb begin
        ctrl = 11'h000;
        case (opcode)
            6'h00:   ctrl = 11'h422;
            6'h23:   ctrl = 11'h0F0;
            6'h2B:   ctrl = 11'h110;
            6'h04:   ctrl = 11'h201;
            6'h08:   ctrl = 11'h030;
            6'h02:   ctrl = 11'h203;
            default: ctrl = 11'h000;
        endcase
    end
    assign bus.control = ctrl;

    always_comb begin
        if (opcode == 6'h02)
            imm = {bus.PC4[SIZE-1 -: 4], bus.Instruction[25:0], 2'b00};
        else
            imm = {{(SIZE-16){bus.Instruction[15]}}, bus.Instruction[15:0]};
    end

    assign dest = ctrl[10] ? rd : bus.rt;

    // Writeback in the same cycle as the read is forwarded so decode never sees a stale value.
    always_comb begin
        if (bus.rs == 5'd0)
            rd1 = '0;
        else if (bus.wbWe && bus.wbAddr == bus.rs)
            rd1 = bus.wbData;
        else
            rd1 = regs_q[bus.rs];
        if (bus.rt == 5'd0)
            rd2 = '0;
        else if (bus.wbWe && bus.wbAddr == bus.rt)
            rd2 = bus.wbData;
        else
            rd2 = regs_q[bus.rt];
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.wbWe && bus.wbAddr != 5'd0)
            regs_d[bus.wbAddr] = bus.wbData;
    end

    // Loads feeding a store or another load are exempt; fetch uses this exact equation.
    assign bus.stall = ctrl_ex_q[6] & ~ctrl[6] & ~ctrl[8] &
                       ((wr_ex_q == bus.rs) | (wr_ex_q == bus.rt));

    always_comb begin
        ctrl_ex_d = '0;
        wr_ex_d   = '0;
        rd1_ex_d  = '0;
        rd2_ex_d  = '0;
        imm_ex_d  = '0;
        pc4_ex_d  = '0;
        if (!bus.redirect && !bus.stall) begin
            ctrl_ex_d = ctrl;
            wr_ex_d   = dest;
            rd1_ex_d  = rd1;
            rd2_ex_d  = rd2;
            imm_ex_d  = imm;
            pc4_ex_d  = bus.PC4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
            ctrl_ex_q <= '0;
            wr_ex_q   <= '0;
            rd1_ex_q  <= '0;
            rd2_ex_q  <= '0;
            imm_ex_q  <= '0;
            pc4_ex_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            ctrl_ex_q <= ctrl_ex_d;
            wr_ex_q   <= wr_ex_d;
            rd1_ex_q  <= rd1_ex_d;
            rd2_ex_q  <= rd2_ex_d;
            imm_ex_q  <= imm_ex_d;
            pc4_ex_q  <= pc4_ex_d;
        end
    end

    assign bus.controlEX   = ctrl_ex_q;
    assign bus.writeRegEX  = wr_ex_q;
    assign bus.readData1EX = rd1_ex_q;
    assign bus.readData2EX = rd2_ex_q;
    assign bus.immEX       = imm_ex_q;
    assign bus.PC4EX       = pc4_ex_q;
endmodule
